// File: rtl/company_vote_ctrl.sv
// Ballot controller for a four-shareholder weighted resolution vote.
// Optional quorum check enabled with `define COMPANY_VOTE_QUORUM_EN.
module company_vote_ctrl #(
    parameter int unsigned WEIGHT_A = 40,
    parameter int unsigned WEIGHT_B = 30,
    parameter int unsigned WEIGHT_C = 20,
    parameter int unsigned WEIGHT_D = 10,
    parameter int unsigned THRESH   = 50,
    parameter int unsigned TIMEOUT  = 16,
    parameter int unsigned QUORUM   = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       start,
    input  logic [3:0] vote_valid,
    input  logic [3:0] vote_val,
    output logic [3:0] vote_ack,
    output logic       busy,
    output logic       done,
    output logic       passed,
    output logic [9:0] yes_weight,
    output logic       timed_out,
    output logic       quorum_fail
);

    localparam int unsigned TW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

`ifdef COMPANY_VOTE_QUORUM_EN
    localparam bit QUORUM_EN = 1'b1;
`else
    localparam bit QUORUM_EN = 1'b0;
`endif

    typedef enum logic [1:0] {
        S_IDLE,
        S_COLLECT,
        S_EVAL,
        S_DONE
    } state_t;

    state_t        r_state;
    state_t        w_next;
    logic [3:0]    r_voted;
    logic [3:0]    r_ballot;
    logic [3:0]    r_ack;
    logic [TW-1:0] r_timer;
    logic          r_passed;
    logic          r_timed_out;
    logic          r_quorum_fail;
    logic [9:0]    r_yes;

    logic [3:0]    w_accept;
    logic [3:0]    w_voted_nxt;
    logic          w_all_voted;
    logic          w_timeout;
    logic [3:0]    w_yes_bits;
    logic [9:0]    w_yes;
    logic [2:0]    w_nvotes;
    logic          w_qfail;
    logic          w_pass;

    // Only first-time strobes are accepted; repeats from a voted shareholder are dropped.
    always_comb begin
        w_accept = '0;
        if (r_state == S_COLLECT) begin
            w_accept = vote_valid & ~r_voted;
        end
    end

    assign w_voted_nxt = r_voted | w_accept;
    assign w_all_voted = &w_voted_nxt;
    assign w_timeout   = (r_timer == TLAST);

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_COLLECT;
            S_COLLECT: if (w_all_voted || w_timeout) w_next = S_EVAL;
            S_EVAL:    w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    assign w_yes_bits = r_voted & r_ballot;

    always_comb begin
        w_yes = '0;
        if (w_yes_bits[3]) w_yes = w_yes + 10'(WEIGHT_A);
        if (w_yes_bits[2]) w_yes = w_yes + 10'(WEIGHT_B);
        if (w_yes_bits[1]) w_yes = w_yes + 10'(WEIGHT_C);
        if (w_yes_bits[0]) w_yes = w_yes + 10'(WEIGHT_D);
    end

    // With the quorum feature disabled the vote count folds away as a constant.
    assign w_nvotes = 3'(r_voted[3]) + 3'(r_voted[2]) + 3'(r_voted[1]) + 3'(r_voted[0]);
    assign w_qfail  = QUORUM_EN && (32'(w_nvotes) < QUORUM);
    assign w_pass   = (32'(w_yes) > THRESH) && !w_qfail;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state       <= S_IDLE;
            r_voted       <= '0;
            r_ballot      <= '0;
            r_ack         <= '0;
            r_timer       <= '0;
            r_passed      <= 1'b0;
            r_timed_out   <= 1'b0;
            r_quorum_fail <= 1'b0;
            r_yes         <= '0;
        end else begin
            r_state <= w_next;
            r_ack   <= w_accept;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        r_voted       <= '0;
                        r_ballot      <= '0;
                        r_timer       <= '0;
                        r_timed_out   <= 1'b0;
                        r_quorum_fail <= 1'b0;
                    end
                end
                S_COLLECT: begin
                    r_voted  <= w_voted_nxt;
                    r_ballot <= (r_ballot & ~w_accept) | (vote_val & w_accept);
                    r_timer  <= r_timer + 1'b1;
                    if (!w_all_voted && w_timeout) begin
                        r_timed_out <= 1'b1;
                    end
                end
                S_EVAL: begin
                    r_yes         <= w_yes;
                    r_passed      <= w_pass;
                    r_quorum_fail <= w_qfail;
                end
                default: ;
            endcase
        end
    end

    assign vote_ack    = r_ack;
    assign busy        = (r_state == S_COLLECT) || (r_state == S_EVAL);
    assign done        = (r_state == S_DONE);
    assign passed      = r_passed;
    assign yes_weight  = r_yes;
    assign timed_out   = r_timed_out;
    assign quorum_fail = r_quorum_fail;

endmodule

// File: tb/tb_company_vote_ctrl.sv
// Scoreboard bench for company_vote_ctrl: a ballot-level model predicts acks and results.
module tb_company_vote_ctrl;

    localparam int TIMEOUT = 16;
    localparam int THRESH  = 50;
    localparam int QUORUM  = 3;

    logic       clk;
    logic       rst_n;
    logic       start;
    logic [3:0] vote_valid;
    logic [3:0] vote_val;
    logic [3:0] vote_ack;
    logic       busy;
    logic       done;
    logic       passed;
    logic [9:0] yes_weight;
    logic       timed_out;
    logic       quorum_fail;

    company_vote_ctrl #(
        .WEIGHT_A(40), .WEIGHT_B(30), .WEIGHT_C(20), .WEIGHT_D(10),
        .THRESH(THRESH), .TIMEOUT(TIMEOUT), .QUORUM(QUORUM)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .vote_valid(vote_valid), .vote_val(vote_val), .vote_ack(vote_ack),
        .busy(busy), .done(done), .passed(passed), .yes_weight(yes_weight),
        .timed_out(timed_out), .quorum_fail(quorum_fail)
    );

    typedef struct {
        logic [3:0] v;
        int         c;
    } ack_t;

    typedef struct {
        int yes;
        bit p;
        bit to;
        bit qf;
        int c;
    } res_t;

    ack_t ack_q[$];
    res_t exp_q[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    int   wt[4]    = '{10, 20, 30, 40};
    logic [3:0] pv [TIMEOUT];
    logic [3:0] pvv[TIMEOUT];
    int   last_yes = 0;
    bit   last_p   = 0;

    initial begin
        clk = 0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            if (vote_ack != 4'b0) begin
                if (ack_q.size() == 0) begin
                    chk("unexpected_ack", 32'(vote_ack), 0);
                end else begin
                    ack_t a;
                    a = ack_q.pop_front();
                    chk("vote_ack", 32'(vote_ack), 32'(a.v));
                    chk("ack_cycle", cyc, a.c);
                end
            end
            if (done) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_done", 32'(done), 0);
                end else begin
                    res_t r;
                    r = exp_q.pop_front();
                    chk("done_cycle", cyc, r.c);
                    chk("yes_weight", 32'(yes_weight), r.yes);
                    chk("passed", 32'(passed), 32'(r.p));
                    chk("timed_out", 32'(timed_out), 32'(r.to));
                    chk("quorum_fail", 32'(quorum_fail), 32'(r.qf));
                    chk("busy_in_done", 32'(busy), 0);
                end
            end
        end
    end

    task automatic clear_plan();
        for (int t = 0; t < TIMEOUT; t++) begin
            pv[t]  = 4'b0;
            pvv[t] = 4'b0;
        end
    endtask

    // Ballot-level model: first vote per shareholder counts, window ends when all
    // four have voted or the TIMEOUT-cycle window is used up.
    task automatic run_ballot();
        logic [3:0] voted;
        logic [3:0] ballot;
        logic [3:0] acc [TIMEOUT];
        int  exit_t;
        int  yes;
        bit  to;
        bit  qf;
        res_t r;
        voted  = 4'b0;
        ballot = 4'b0;
        exit_t = TIMEOUT - 1;
        to     = 1;
        for (int t = 0; t < TIMEOUT; t++) acc[t] = 4'b0;
        for (int t = 0; t < TIMEOUT; t++) begin
            acc[t] = pv[t] & ~voted;
            ballot = ballot | (acc[t] & pvv[t]);
            voted  = voted | acc[t];
            if (voted == 4'hF) begin
                exit_t = t;
                to     = 0;
                break;
            end
        end
        yes = 0;
        for (int i = 0; i < 4; i++) if (voted[i] && ballot[i]) yes += wt[i];
`ifdef COMPANY_VOTE_QUORUM_EN
        qf = ($countones(voted) < QUORUM);
`else
        qf = 0;
`endif
        r.yes = yes;
        r.p   = (yes > THRESH) && !qf;
        r.to  = to;
        r.qf  = qf;

        start = 1;
        @(posedge clk); #1;
        for (int t = 0; t <= exit_t; t++) begin
            vote_valid = pv[t];
            vote_val   = pvv[t];
            start      = ($urandom_range(0, 3) == 0);
            @(posedge clk); #1;
            if (acc[t] != 4'b0) ack_q.push_back('{v: acc[t], c: cyc});
            if (t == exit_t) begin
                r.c = cyc + 1;
                exp_q.push_back(r);
            end
        end
        // EVAL and DONE cycles: stray votes and start must be ignored
        for (int k = 0; k < 2; k++) begin
            start      = 1;
            vote_valid = 4'($urandom);
            vote_val   = 4'($urandom);
            @(posedge clk); #1;
        end
        start      = 0;
        vote_valid = 4'b0;
        vote_val   = 4'b0;
        for (int k = 0; k < 20 && exp_q.size() != 0; k++) @(posedge clk); #1;
        if (exp_q.size() != 0) begin
            chk("done_wait_expired", 32'(exp_q.size()), 0);
            exp_q.delete();
        end
        @(posedge clk); #1;
        @(posedge clk); #1;
        chk("idle_busy", 32'(busy), 0);
        chk("idle_hold_yes", 32'(yes_weight), r.yes);
        chk("idle_hold_passed", 32'(passed), 32'(r.p));
        last_yes = r.yes;
        last_p   = r.p;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n      = 0;
        start      = 0;
        vote_valid = 0;
        vote_val   = 0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1;
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_yes", 32'(yes_weight), 0);
        chk("rst_passed", 32'(passed), 0);
        chk("rst_ack", 32'(vote_ack), 0);
        chk("rst_timed_out", 32'(timed_out), 0);
        @(posedge clk); #1;

        // all yes in one cycle
        clear_plan();
        pv[0] = 4'hF; pvv[0] = 4'hF;
        run_ballot();
        // A, D yes; B, C no; exactly at threshold
        clear_plan();
        pv[0] = 4'h8; pvv[0] = 4'h8;
        pv[1] = 4'h1; pvv[1] = 4'h1;
        pv[2] = 4'h4; pvv[2] = 4'h0;
        pv[3] = 4'h2; pvv[3] = 4'h0;
        run_ballot();
        // only B and C vote -> timeout
        clear_plan();
        pv[0] = 4'h4; pvv[0] = 4'h4;
        pv[2] = 4'h2; pvv[2] = 4'h2;
        run_ballot();
        // A re-votes no; repeat strobe must be ignored
        clear_plan();
        pv[0] = 4'h8; pvv[0] = 4'h8;
        pv[1] = 4'h8; pvv[1] = 4'h0;
        pv[2] = 4'h4; pvv[2] = 4'h0;
        pv[3] = 4'h2; pvv[3] = 4'h0;
        pv[4] = 4'h1; pvv[4] = 4'h0;
        run_ballot();
        // D completes the ballot on the last window cycle
        clear_plan();
        pv[0] = 4'h8;  pvv[0] = 4'h8;
        pv[3] = 4'h4;  pvv[3] = 4'h4;
        pv[6] = 4'h2;  pvv[6] = 4'h2;
        pv[TIMEOUT-1] = 4'h1; pvv[TIMEOUT-1] = 4'h1;
        run_ballot();

        // reset mid-ballot: A's ack is seen, but no done may follow
        start = 1;
        @(posedge clk); #1;
        start = 0;
        vote_valid = 4'h8; vote_val = 4'h8;
        @(posedge clk); #1;
        ack_q.push_back('{v: 4'h8, c: cyc});
        vote_valid = 4'h0; vote_val = 4'h0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        start = 1;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 0;
        start = 0;
        @(posedge clk); #1;
        rst_n = 1;
        chk("abort_busy", 32'(busy), 0);
        chk("abort_yes", 32'(yes_weight), 0);
        chk("abort_passed", 32'(passed), 0);
        chk("abort_ack", 32'(vote_ack), 0);
        repeat (3) @(posedge clk);
        #1;
        chk("abort_no_done_busy", 32'(busy), 0);
        clear_plan();
        pv[0] = 4'h8; pvv[0] = 4'h0;
        pv[1] = 4'h6; pvv[1] = 4'h6;
        pv[2] = 4'h1; pvv[2] = 4'h0;
        run_ballot();

        // randomized ballots, sparse ones tend to time out
        for (int b = 0; b < 30; b++) begin
            int dens;
            dens = $urandom_range(1, 8);
            clear_plan();
            for (int t = 0; t < TIMEOUT; t++) begin
                if ($urandom_range(0, dens - 1) == 0) pv[t] = 4'($urandom);
                pvv[t] = 4'($urandom);
            end
            run_ballot();
        end

        repeat (4) @(posedge clk);
        #1;
        chk("ack_queue_drained", 32'(ack_q.size()), 0);
        chk("result_queue_drained", 32'(exp_q.size()), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/company_vote_ctrl.md
Name: company_vote_ctrl

Overview:
- Sequences one company-resolution ballot among four shareholders A, B, C, D.
- Opens a voting window on start and collects one vote per shareholder over a valid/ack handshake; bounded by a timeout.
- Computes the weighted yes total and latches a pass/fail result plus status flags.
- Sits in front of the resolution logic as its ballot controller.

Parameters:
- WEIGHT_A, 40, vote weight of shareholder A (index 3)
- WEIGHT_B, 30, vote weight of shareholder B (index 2)
- WEIGHT_C, 20, vote weight of shareholder C (index 1)
- WEIGHT_D, 10, vote weight of shareholder D (index 0)
- THRESH, 50, resolution passes only when yes_weight > THRESH (strict)
- TIMEOUT, 16, maximum COLLECT cycles before forced evaluation (>=1)
- QUORUM, 3, minimum votes cast when QUORUM_EN is defined

Ports:
- clk  in  1  single system clock, rising edge
- rst_n  in  1  synchronous active-low reset
- start  in  1  open a ballot; honoured only in IDLE
- vote_valid  in  4  per-shareholder vote strobe, [3]=A ... [0]=D
- vote_val  in  4  per-shareholder vote value, 1=yes 0=no
- vote_ack  out  4  one-cycle acknowledge of an accepted vote
- busy  out  1  high in COLLECT and EVAL
- done  out  1  one-cycle pulse when the result is valid
- passed  out  1  latched resolution result
- yes_weight  out  10  latched weighted yes sum
- timed_out  out  1  latched: ballot closed by timeout
- quorum_fail  out  1  latched: quorum not met (0 without QUORUM_EN)

Behaviour:
- Clocking and reset: one clock; reset is synchronous and active-low (rst_n sampled on rising clk).
- Reset values: state=IDLE; all outputs 0; internal voted[3:0], ballot[3:0] and timer cleared. Reset mid-ballot aborts with no done pulse.
- States: IDLE, COLLECT, EVAL, DONE.
- IDLE:
  - start=1: go to COLLECT; clear voted, ballot, timer, timed_out, quorum_fail.
  - passed and yes_weight keep the previous ballot's values until EVAL overwrites them.
- COLLECT:
  - For each i with vote_valid[i]=1 and voted[i]=0: latch ballot[i]<=vote_val[i], set voted[i], drive vote_ack[i]=1 in the next cycle only.
  - Repeat votes from a shareholder already voted are ignored: no ack, no change.
  - Several shareholders may vote in the same cycle; all are accepted.
  - Timer increments each COLLECT cycle.
- COLLECT exit conditions:
  - If voted (including votes accepted this edge) becomes 4'b1111: next state EVAL.
  - Else if timer==TIMEOUT-1: next state EVAL and timed_out<=1. Votes arriving on that final cycle are accepted and counted.
  - All voted on the timeout cycle: timed_out stays 0.
- EVAL (1 cycle):
  - yes_weight <= sum of WEIGHT_x over shareholders with voted & ballot set. Missing votes count as no.
  - passed <= (yes_weight > THRESH). Next state DONE.
- DONE (1 cycle): done=1; then IDLE. busy=0 in DONE.
- Start handling: start ignored outside IDLE; start asserted in DONE is ignored.
- Latency: done asserts 2 cycles after the edge latching the final vote, or 2 cycles after the timeout edge.
- Arithmetic: 10-bit unsigned sum, no overflow for weights <=255. Compare is unsigned.

Optional Feature:
- Macro: COMPANY_VOTE_QUORUM_EN.
- Defined: in EVAL, count ones in voted. If count < QUORUM, then quorum_fail<=1 and passed<=0; yes_weight is still computed and reported.
- Undefined: quorum_fail tied 0; no vote counting; QUORUM unused.

Test Plan:
- Reset, start, all four vote yes in one cycle -> vote_ack=4'b1111 next cycle, done 2 cycles after vote edge, yes_weight=100, passed=1, timed_out=0.
- Votes A=1, D=1, B=0, C=0 on separate cycles -> yes_weight=50, passed=0 (strict boundary).
- Only B=1, C=1 vote, then idle until timeout -> EVAL after 16 COLLECT cycles, timed_out=1, yes_weight=50, passed=0; with QUORUM_EN, quorum_fail=1.
- A votes yes then re-votes no, others vote no -> second strobe gets no ack, yes_weight=40, passed=0.
- D votes on cycle TIMEOUT-1 completing the ballot; A=B=C=1 earlier -> timed_out=0, yes_weight=100, passed=1.
- rst_n=0 mid-COLLECT after A voted, then restart with A=0, B=1, C=1, D=0 -> no done from the aborted ballot, new result yes_weight=50, passed=0; start pulses while busy have no effect.
